// File: rtl/mbist_sequencer.sv
// rtl/mbist_sequencer.sv - MBIST scheduler stepping a masked algorithm list into the control decoder
module mbist_sequencer #(
    parameter int NUM_ALGS   = 6,
    parameter int TIMEOUT_W  = 16,
    parameter int GAP_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [NUM_ALGS-1:0] alg_mask,
    input  logic                alg_done,
    input  logic                alg_fail,
    output logic [3:0]          select,
    output logic [2:0]          cur_alg,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [NUM_ALGS-1:0] fail_map,
    output logic                timeout_err
);
    localparam int                   GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0]     GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] TIMER_MAX = '1;

    typedef enum logic [2:0] {S_IDLE, S_SELECT, S_RUN, S_GAP, S_DONE} state_t;

    state_t                state, state_nx;
    logic [3:0]            select_nx;
    logic [2:0]            cur_alg_nx;
    logic                  busy_nx, done_nx, pass_nx, timeout_err_nx;
    logic [NUM_ALGS-1:0]   fail_map_nx, mask_q, mask_nx;
    logic [TIMEOUT_W-1:0]  timer, timer_nx;
    logic [GAP_W-1:0]      gap_cnt, gap_cnt_nx;
    logic [3:0]            first_hit, next_hit;

    // Lowest set bit of m at or above index 'from'; bit 3 flags a hit, bits 2:0 the index.
    function automatic logic [3:0] pick_from(input logic [NUM_ALGS-1:0] m, input int from);
        logic [3:0] r;
        r = 4'd0;
        for (int i = NUM_ALGS - 1; i >= 0; i--) begin
            if (m[i] && (i >= from)) begin
                r = {1'b1, 3'(i)};
            end
        end
        return r;
    endfunction

    assign first_hit = pick_from(alg_mask, 0);
    assign next_hit  = pick_from(mask_q, int'(cur_alg) + 1);

    // Next-state and next-output logic; abort overrides every state including a start.
    always_comb begin
        state_nx       = state;
        select_nx      = select;
        cur_alg_nx     = cur_alg;
        busy_nx        = busy;
        done_nx        = 1'b0;
        pass_nx        = pass;
        fail_map_nx    = fail_map;
        timeout_err_nx = timeout_err;
        mask_nx        = mask_q;
        timer_nx       = timer;
        gap_cnt_nx     = gap_cnt;
        if (abort) begin
            state_nx  = S_IDLE;
            select_nx = 4'd0;
            busy_nx   = 1'b0;
            pass_nx   = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mask_nx        = alg_mask;
                        fail_map_nx    = '0;
                        timeout_err_nx = 1'b0;
                        pass_nx        = 1'b0;
                        busy_nx        = 1'b1;
                        if (first_hit[3]) begin
                            cur_alg_nx = first_hit[2:0];
                            state_nx   = S_SELECT;
                        end else begin
                            state_nx   = S_DONE;
                        end
                    end
                end
                S_SELECT: begin
                    select_nx = {1'b0, cur_alg} + 4'd1;
                    timer_nx  = '0;
                    state_nx  = S_RUN;
                end
                S_RUN: begin
                    if (alg_done) begin
                        fail_map_nx[cur_alg] = alg_fail;
                        select_nx            = 4'd0;
                        gap_cnt_nx           = '0;
                        state_nx             = S_GAP;
                    end else if (timer == TIMER_MAX) begin
                        fail_map_nx[cur_alg] = 1'b1;
                        timeout_err_nx       = 1'b1;
                        select_nx            = 4'd0;
                        gap_cnt_nx           = '0;
                        state_nx             = S_GAP;
                    end else begin
                        timer_nx = timer + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        if (next_hit[3]) begin
                            cur_alg_nx = next_hit[2:0];
                            state_nx   = S_SELECT;
                        end else begin
                            state_nx   = S_DONE;
                        end
                    end else begin
                        gap_cnt_nx = gap_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    done_nx  = 1'b1;
                    pass_nx  = ~|fail_map;
                    busy_nx  = 1'b0;
                    state_nx = S_IDLE;
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // State and registered outputs; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            select      <= 4'd0;
            cur_alg     <= 3'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_map    <= '0;
            timeout_err <= 1'b0;
            mask_q      <= '0;
            timer       <= '0;
            gap_cnt     <= '0;
        end else begin
            state       <= state_nx;
            select      <= select_nx;
            cur_alg     <= cur_alg_nx;
            busy        <= busy_nx;
            done        <= done_nx;
            pass        <= pass_nx;
            fail_map    <= fail_map_nx;
            timeout_err <= timeout_err_nx;
            mask_q      <= mask_nx;
            timer       <= timer_nx;
            gap_cnt     <= gap_cnt_nx;
        end
    end
endmodule
